// File: rtl/msf_frame_decoder_if.sv
// Bus between the MSF pulse demodulator and the frame decoder, plus the decoded digit outputs.
interface msf_frame_decoder_if;
  logic       sec_valid_i;
  logic       sec_a_i;
  logic       sec_b_i;
  logic       minute_mark_i;
  logic       load_o;
  logic [3:0] year_h_o;
  logic [3:0] year_l_o;
  logic [0:0] month_h_o;
  logic [3:0] month_l_o;
  logic [1:0] day_h_o;
  logic [3:0] day_l_o;
  logic [1:0] hour_h_o;
  logic [3:0] hour_l_o;
  logic [2:0] minute_h_o;
  logic [3:0] minute_l_o;
  logic [2:0] second_h_o;
  logic [3:0] second_l_o;
  logic       sync_o;
  logic       err_o;

  modport master (
    output sec_valid_i, sec_a_i, sec_b_i, minute_mark_i,
    input  load_o, year_h_o, year_l_o, month_h_o, month_l_o, day_h_o, day_l_o,
           hour_h_o, hour_l_o, minute_h_o, minute_l_o, second_h_o, second_l_o,
           sync_o, err_o
  );

  modport slave (
    input  sec_valid_i, sec_a_i, sec_b_i, minute_mark_i,
    output load_o, year_h_o, year_l_o, month_h_o, month_l_o, day_h_o, day_l_o,
           hour_h_o, hour_l_o, minute_h_o, minute_l_o, second_h_o, second_l_o,
           sync_o, err_o
  );
endinterface

// File: rtl/msf_frame_decoder.sv
// Collects one MSF minute of A/B bits, validates markers, parity and ranges,
// and loads BCD date/time digits at the marker that closes the frame.
module msf_frame_decoder (
  input logic                clk_i,
  input logic                rst_ni,
  msf_frame_decoder_if.slave bus
);
  localparam int unsigned CntW   = 6;
  localparam int unsigned ShW    = 43;  // A bits of seconds 17..59
  localparam int unsigned BW     = 4;   // B bits of seconds 54..57
  localparam int unsigned TimeW  = 32;
  localparam int unsigned FirstA = 17;
  localparam int unsigned FirstB = 54;
  localparam int unsigned LastB  = 57;
  localparam logic [CntW-1:0] LastSec = CntW'(59);

  typedef enum logic {HUNT, RECEIVE} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d, idx;
  logic [ShW-1:0]     a_q, a_d;   // MSB-first shift: second s sits at bit 59-s
  logic [BW-1:0]      b_q, b_d;   // bit 3 = 54B ... bit 0 = 57B
  logic [TimeW-1:0]   time_q, time_d, cand;
  logic               load_q, load_d, err_q, err_d, sync_q, sync_d;
  logic               parity_ok, marker_ok, range_ok, frame_ok;

  // Candidate digits: year..day (seconds 17-35) and hour..minute (39-51), skipping day-of-week.
  assign cand = {a_q[42:24], a_q[20:8]};

  assign marker_ok = (a_q[7:0] == 8'b0111_1110);
  assign parity_ok = (^{a_q[42:35], b_q[3]}) & (^{a_q[34:24], b_q[2]}) &
                     (^{a_q[23:21], b_q[1]}) & (^{a_q[20:8],  b_q[0]});

  // BCD and calendar range checks on the candidate digits.
  always_comb begin
    range_ok = (cand[27:24] <= 4'd9) && (cand[22:19] <= 4'd9) && (cand[16:13] <= 4'd9) &&
               (cand[10:7] <= 4'd9) && (cand[3:0] <= 4'd9) && (cand[6:4] <= 3'd5);
    if (cand[23]) range_ok = range_ok && (cand[22:19] <= 4'd2);
    else          range_ok = range_ok && (cand[22:19] != 4'd0);
    if (cand[18:17] == 2'd0)      range_ok = range_ok && (cand[16:13] != 4'd0);
    else if (cand[18:17] == 2'd3) range_ok = range_ok && (cand[16:13] <= 4'd1);
    if (cand[12:11] == 2'd2)      range_ok = range_ok && (cand[10:7] <= 4'd3);
    else if (cand[12:11] == 2'd3) range_ok = 1'b0;
  end

  assign frame_ok = (cnt_q == LastSec) && marker_ok && parity_ok && range_ok;
  assign idx      = CntW'(cnt_q + CntW'(1));

  // Next-state, capture and output decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    time_d  = time_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    sync_d  = sync_q;
    case (state_q)
      HUNT: begin
        if (bus.minute_mark_i) begin
          state_d = RECEIVE;
          cnt_d   = '0;
          a_d     = '0;
          b_d     = '0;
        end
      end
      RECEIVE: begin
        if (bus.minute_mark_i) begin
          if (frame_ok) begin
            time_d = cand;
            load_d = 1'b1;
            sync_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            sync_d = 1'b0;
          end
          cnt_d = '0;
          a_d   = '0;
          b_d   = '0;
        end else if (bus.sec_valid_i) begin
          if (cnt_q == LastSec) begin
            err_d   = 1'b1;
            sync_d  = 1'b0;
            state_d = HUNT;
            cnt_d   = '0;
          end else begin
            cnt_d = idx;
            if (idx >= CntW'(FirstA)) a_d = {a_q[ShW-2:0], bus.sec_a_i};
            if ((idx >= CntW'(FirstB)) && (idx <= CntW'(LastB))) b_d = {b_q[BW-2:0], bus.sec_b_i};
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      time_q  <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      time_q  <= time_d;
      load_q  <= load_d;
      err_q   <= err_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.load_o     = load_q;
  assign bus.err_o      = err_q;
  assign bus.sync_o     = sync_q;
  assign bus.year_h_o   = time_q[31:28];
  assign bus.year_l_o   = time_q[27:24];
  assign bus.month_h_o  = time_q[23:23];
  assign bus.month_l_o  = time_q[22:19];
  assign bus.day_h_o    = time_q[18:17];
  assign bus.day_l_o    = time_q[16:13];
  assign bus.hour_h_o   = time_q[12:11];
  assign bus.hour_l_o   = time_q[10:7];
  assign bus.minute_h_o = time_q[6:4];
  assign bus.minute_l_o = time_q[3:0];
  assign bus.second_h_o = 3'd0;
  assign bus.second_l_o = 4'd0;
endmodule

// File: tb/tb_msf_frame_decoder.sv
// Self-checking bench for msf_frame_decoder: directed test-plan cases plus random frames
// judged by a second-indexed frame model.
module tb_msf_frame_decoder;
  logic clk;
  logic rst_ni;

  msf_frame_decoder_if bus ();

  msf_frame_decoder dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: bits received since the last marker, hunt flag, sync level, held digits.
  bit qa[$];
  bit qb[$];
  bit m_hunt = 1'b1;
  bit m_sync = 1'b0;
  int m_f [10];
  int c_f [10];
  int lo_t [10] = '{17, 21, 25, 26, 30, 32, 39, 41, 45, 48};
  int hi_t [10] = '{20, 24, 25, 29, 31, 35, 40, 44, 47, 51};

  bit [59:0] fa;
  bit [59:0] fb;

  // Compare one observed value against the bench's expectation.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value of seconds lo..hi, earliest second most significant.
  function automatic int fval(input bit [59:0] f, input int lo, input int hi);
    int v = 0;
    for (int s = lo; s <= hi; s++) v = v * 2 + int'(f[s]);
    return v;
  endfunction

  function automatic int ones(input bit [59:0] f, input int lo, input int hi);
    int n = 0;
    for (int s = lo; s <= hi; s++) n += int'(f[s]);
    return n;
  endfunction

  // Judge the frame held in the queues against the time-code rules; fields land in c_f.
  function automatic bit model_valid();
    bit [59:0] ra = '0;
    bit [59:0] rb = '0;
    int mon, day, hr;
    foreach (qa[i]) begin
      ra[i + 1] = qa[i];
      rb[i + 1] = qb[i];
    end
    for (int k = 0; k < 10; k++) c_f[k] = fval(ra, lo_t[k], hi_t[k]);
    if (qa.size() != 59) return 1'b0;
    if (fval(ra, 52, 59) != 'h7E) return 1'b0;
    if ((ones(ra, 17, 24) + int'(rb[54])) % 2 == 0) return 1'b0;
    if ((ones(ra, 25, 35) + int'(rb[55])) % 2 == 0) return 1'b0;
    if ((ones(ra, 36, 38) + int'(rb[56])) % 2 == 0) return 1'b0;
    if ((ones(ra, 39, 51) + int'(rb[57])) % 2 == 0) return 1'b0;
    for (int k = 1; k < 10; k += 2) if (c_f[k] > 9) return 1'b0;
    mon = 10 * c_f[2] + c_f[3];
    day = 10 * c_f[4] + c_f[5];
    hr  = 10 * c_f[6] + c_f[7];
    if (mon < 1 || mon > 12) return 1'b0;
    if (day < 1 || day > 31) return 1'b0;
    if (hr > 23) return 1'b0;
    if (c_f[8] > 5) return 1'b0;
    return 1'b1;
  endfunction

  // Encode a date/time as a frame with correct markers and odd parity into fa/fb.
  task automatic build(input int y, input int mo, input int d, input int dow, input int h, input int mi);
    int v [10];
    int x;
    fa = '0;
    fb = '0;
    for (int s = 1; s <= 16; s++) fa[s] = 1'($urandom);
    for (int s = 1; s <= 59; s++) fb[s] = 1'($urandom);
    v = '{y / 10, y % 10, mo / 10, mo % 10, d / 10, d % 10, h / 10, h % 10, mi / 10, mi % 10};
    for (int k = 0; k < 10; k++) begin
      x = v[k];
      for (int s = hi_t[k]; s >= lo_t[k]; s--) begin
        fa[s] = x[0];
        x = x >> 1;
      end
    end
    x = dow;
    for (int s = 38; s >= 36; s--) begin
      fa[s] = x[0];
      x = x >> 1;
    end
    for (int s = 52; s <= 59; s++) fa[s] = (s >= 53 && s <= 58);
    fb[54] = (ones(fa, 17, 24) % 2 == 0);
    fb[55] = (ones(fa, 25, 35) % 2 == 0);
    fb[56] = (ones(fa, 36, 38) % 2 == 0);
    fb[57] = (ones(fa, 39, 51) % 2 == 0);
  endtask

  // Drive seconds 1..n of fa/fb on consecutive cycles.
  task automatic send_secs(input int n);
    for (int s = 1; s <= n; s++) begin
      @(negedge clk);
      bus.sec_valid_i = 1'b1;
      bus.sec_a_i     = fa[s];
      bus.sec_b_i     = fb[s];
      if (!m_hunt) begin
        qa.push_back(fa[s]);
        qb.push_back(fb[s]);
      end
    end
    @(negedge clk);
    bus.sec_valid_i = 1'b0;
  endtask

  task automatic check_all(input string tag, input bit el, input bit ee);
    chk({tag, ".load"},   bus.load_o, 32'(el));
    chk({tag, ".err"},    bus.err_o, 32'(ee));
    chk({tag, ".sync"},   bus.sync_o, 32'(m_sync));
    chk({tag, ".year_h"}, bus.year_h_o, m_f[0]);
    chk({tag, ".year_l"}, bus.year_l_o, m_f[1]);
    chk({tag, ".mon_h"},  bus.month_h_o, m_f[2]);
    chk({tag, ".mon_l"},  bus.month_l_o, m_f[3]);
    chk({tag, ".day_h"},  bus.day_h_o, m_f[4]);
    chk({tag, ".day_l"},  bus.day_l_o, m_f[5]);
    chk({tag, ".hour_h"}, bus.hour_h_o, m_f[6]);
    chk({tag, ".hour_l"}, bus.hour_l_o, m_f[7]);
    chk({tag, ".min_h"},  bus.minute_h_o, m_f[8]);
    chk({tag, ".min_l"},  bus.minute_l_o, m_f[9]);
    chk({tag, ".sec_h"},  bus.second_h_o, 0);
    chk({tag, ".sec_l"},  bus.second_l_o, 0);
  endtask

  // Issue a minute marker (optionally with a coincident second) and check the response.
  task automatic do_mark(input bit with_sec, input string tag);
    bit el = 1'b0;
    bit ee = 1'b0;
    if (!m_hunt) begin
      if (model_valid()) begin
        el     = 1'b1;
        m_sync = 1'b1;
        m_f    = c_f;
      end else begin
        ee     = 1'b1;
        m_sync = 1'b0;
      end
    end
    m_hunt = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    bus.minute_mark_i = 1'b1;
    bus.sec_valid_i   = with_sec;
    bus.sec_a_i       = 1'b1;
    bus.sec_b_i       = 1'b1;
    @(negedge clk);
    bus.minute_mark_i = 1'b0;
    bus.sec_valid_i   = 1'b0;
    check_all(tag, el, ee);
    @(negedge clk);
    chk({tag, ".load_1cyc"}, bus.load_o, 0);
    chk({tag, ".err_1cyc"},  bus.err_o, 0);
  endtask

  task automatic model_reset();
    m_hunt = 1'b1;
    m_sync = 1'b0;
    foreach (m_f[k]) m_f[k] = 0;
    qa.delete();
    qb.delete();
  endtask

  initial begin
    int kind;
    int y, mo, d, h, mi, n;
    rst_ni            = 1'b0;
    bus.sec_valid_i   = 1'b0;
    bus.sec_a_i       = 1'b0;
    bus.sec_b_i       = 1'b0;
    bus.minute_mark_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0, 1'b0);
    rst_ni = 1'b1;

    // First marker after hunt only starts a frame.
    build(23, 3, 14, 2, 15, 26);
    send_secs(10);
    do_mark(1'b0, "first");

    // Reference frame 23-03-14 15:26.
    build(23, 3, 14, 2, 15, 26);
    send_secs(59);
    do_mark(1'b0, "valid");
    chk("tp.year",   {bus.year_h_o, bus.year_l_o}, 32'h23);
    chk("tp.month",  {bus.month_h_o, bus.month_l_o}, 32'h03);
    chk("tp.day",    {bus.day_h_o, bus.day_l_o}, 32'h14);
    chk("tp.hour",   {bus.hour_h_o, bus.hour_l_o}, 32'h15);
    chk("tp.minute", {bus.minute_h_o, bus.minute_l_o}, 32'h26);
    chk("tp.sync",   bus.sync_o, 1);

    // Parity fault on 57B.
    build(23, 3, 14, 2, 15, 27);
    fb[57] = ~fb[57];
    send_secs(59);
    do_mark(1'b0, "parity");
    chk("tp.par_hold", {bus.minute_h_o, bus.minute_l_o}, 32'h26);

    // Short frame, then a good frame.
    build(23, 3, 14, 2, 15, 28);
    send_secs(58);
    do_mark(1'b0, "short");
    build(23, 3, 14, 2, 15, 29);
    send_secs(59);
    do_mark(1'b0, "after_short");

    // Month 13 with consistent parity.
    build(23, 13, 14, 2, 15, 30);
    send_secs(59);
    do_mark(1'b0, "month13");

    // Marker coincident with a second strobe.
    build(24, 12, 31, 6, 23, 59);
    send_secs(59);
    do_mark(1'b1, "coincident");
    build(25, 1, 1, 3, 0, 0);
    send_secs(59);
    do_mark(1'b0, "after_coinc");

    // Overrun: a 60th second with no marker.
    build(25, 1, 1, 3, 0, 1);
    send_secs(59);
    @(negedge clk);
    bus.sec_valid_i = 1'b1;
    bus.sec_a_i     = 1'b0;
    @(negedge clk);
    bus.sec_valid_i = 1'b0;
    m_sync = 1'b0;
    m_hunt = 1'b1;
    qa.delete();
    qb.delete();
    chk("overrun.err",  bus.err_o, 1);
    chk("overrun.load", bus.load_o, 0);
    chk("overrun.sync", bus.sync_o, 0);
    do_mark(1'b0, "post_overrun");
    build(25, 1, 1, 3, 0, 2);
    send_secs(59);
    do_mark(1'b0, "resync");

    // Random frames with assorted corruptions.
    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 5));
      y  = int'($urandom_range(0, 99));
      mo = int'($urandom_range(1, 12));
      d  = int'($urandom_range(1, 31));
      h  = int'($urandom_range(0, 23));
      mi = int'($urandom_range(0, 59));
      n  = 59;
      if (kind == 3) begin
        case ($urandom_range(0, 3))
          0:       h  = int'($urandom_range(24, 29));
          1:       mi = int'($urandom_range(60, 79));
          2:       d  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(32, 39));
          default: mo = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(13, 19));
        endcase
      end
      build(y, mo, d, int'($urandom_range(0, 6)), h, mi);
      if (kind == 1) fb[54 + int'($urandom_range(0, 3))] ^= 1'b1;
      if (kind == 2) fa[52 + int'($urandom_range(0, 7))] ^= 1'b1;
      if (kind == 4) n = int'($urandom_range(50, 58));
      if (kind == 5) fa[int'($urandom_range(17, 51))] ^= 1'b1;
      send_secs(n);
      do_mark(1'b0, $sformatf("rand%0d", it));
    end

    // Reset in the middle of a valid frame.
    build(26, 6, 15, 1, 12, 0);
    send_secs(29);
    @(negedge clk);
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_all("midreset", 1'b0, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    do_mark(1'b0, "post_reset");
    build(26, 6, 15, 1, 12, 1);
    send_secs(59);
    do_mark(1'b0, "post_reset_valid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
